// File: rtl/hssim_pkg.sv
// Shared HSSIM constants, the divider special-case code and the ratio-stage latency.
package hssim_pkg;

  localparam int unsigned FRAC_BITS       = 14;
  localparam int unsigned ONE             = 32'd1 << FRAC_BITS;
  localparam int unsigned BEATS_PER_FRAME = (512 * 512) / 16;

  // Downstream delay-matching logic aligns side-band data to this latency.
  localparam int unsigned HSSIM_RATIO_LAT = FRAC_BITS + 2;

  typedef enum logic [1:0] {
    SPC_NORMAL = 2'd0,
    SPC_ZERO   = 2'd1,
    SPC_SAT    = 2'd2
  } spc_e;

  // Non-positive denominator forces zero; |n| >= d saturates to +/-ONE.
  function automatic spc_e spc_classify(input logic den_pos, input logic abs_ge_den);
    spc_e spc;
    if (!den_pos) begin
      spc = SPC_ZERO;
    end else if (abs_ge_den) begin
      spc = SPC_SAT;
    end else begin
      spc = SPC_NORMAL;
    end
    return spc;
  endfunction

endpackage

// File: rtl/hssim_ratio_if.sv
// Beat bus between the HSSIM numerator/denominator generator, the ratio stage and pooling.
interface hssim_ratio_if #(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned NUMR_BIT_WIDTH  = 36,
  parameter int unsigned DENR_BIT_WIDTH  = 36,
  parameter int unsigned OUT_BIT_WIDTH   = 16
);

  logic                                      in_valid;
  logic [NUMR_BIT_WIDTH*PIXELS_PER_BEAT-1:0] numr_in;
  logic [DENR_BIT_WIDTH*PIXELS_PER_BEAT-1:0] denr_in;
  logic [OUT_BIT_WIDTH*PIXELS_PER_BEAT-1:0]  ssim_out;
  logic                                      out_valid;
  logic                                      out_last;

  modport master (
    output in_valid, numr_in, denr_in,
    input  ssim_out, out_valid, out_last
  );

  modport slave (
    input  in_valid, numr_in, denr_in,
    output ssim_out, out_valid, out_last
  );

endinterface

// File: rtl/hssim_div_lane.sv
// One lane of the SSIM ratio: signed n/d clamped to [-ONE, +ONE] as Q2.FRAC_BITS,
// computed by a restoring divider resolving one quotient bit per pipeline stage.
module hssim_div_lane
  import hssim_pkg::*;
#(
  parameter int unsigned NUMR_W = 36,
  parameter int unsigned DENR_W = 36,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic [NUMR_W-1:0] i_numr,
  input  logic [DENR_W-1:0] i_denr,
  output logic [OUT_W-1:0]  o_ssim
);

  // |n| needs one extra bit so the most-negative numerator stays representable.
  localparam int unsigned ABS_W = NUMR_W + 1;
  localparam int unsigned REM_W = DENR_W + 1;
  localparam int unsigned CMP_W = (ABS_W > REM_W) ? ABS_W : REM_W;

  logic             w_neg;
  logic             w_den_pos;
  logic             w_abs_ge;
  logic [ABS_W-1:0] w_numr_ext;
  logic [ABS_W-1:0] w_abs;
  spc_e             w_spc;
  logic [OUT_W-1:0] w_mag;
  logic [OUT_W-1:0] w_result;

  logic [REM_W-1:0]     r_rem [FRAC_BITS];
  logic [DENR_W-1:0]    r_den [FRAC_BITS];
  logic [FRAC_BITS-1:0] r_quo [1:FRAC_BITS];
  logic                 r_neg [FRAC_BITS+1];
  spc_e                 r_spc [FRAC_BITS+1];

  // Shifted partial remainder fits the divisor: this stage's quotient bit is 1.
  function automatic logic div_ge(input logic [REM_W-1:0] rem, input logic [DENR_W-1:0] den);
    return {rem, 1'b0} >= {2'b00, den};
  endfunction

  // Next partial remainder: shift, then subtract the divisor when it fits.
  function automatic logic [REM_W-1:0] div_rem(input logic [REM_W-1:0] rem,
                                               input logic [DENR_W-1:0] den);
    logic [REM_W:0] shl;
    shl = {rem, 1'b0};
    if (div_ge(rem, den)) begin
      return REM_W'(shl - {2'b00, den});
    end
    return REM_W'(shl);
  endfunction

  assign w_neg      = i_numr[NUMR_W-1];
  assign w_numr_ext = {i_numr[NUMR_W-1], i_numr};
  assign w_abs      = w_neg ? (~w_numr_ext + ABS_W'(1)) : w_numr_ext;
  assign w_den_pos  = !i_denr[DENR_W-1] && (i_denr != '0);
  assign w_abs_ge   = CMP_W'(w_abs) >= CMP_W'(i_denr);
  assign w_spc      = spc_classify(w_den_pos, w_abs_ge);

  // Final stage: pick magnitude from the special code, then apply the numerator sign.
  always_comb begin
    w_mag    = '0;
    w_result = '0;
    case (r_spc[FRAC_BITS])
      SPC_SAT:    w_mag = OUT_W'(ONE);
      SPC_NORMAL: w_mag = OUT_W'(r_quo[FRAC_BITS]);
      default:    w_mag = '0;
    endcase
    w_result = r_neg[FRAC_BITS] ? (~w_mag + OUT_W'(1)) : w_mag;
  end

  // Divider pipeline: stage 0 conditions operands, stages 1..FRAC_BITS each add one quotient bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FRAC_BITS; k++) begin
        r_rem[k] <= '0;
        r_den[k] <= '0;
      end
      for (int k = 1; k <= FRAC_BITS; k++) begin
        r_quo[k] <= '0;
      end
      for (int k = 0; k <= FRAC_BITS; k++) begin
        r_neg[k] <= 1'b0;
        r_spc[k] <= SPC_ZERO;
      end
      o_ssim <= '0;
    end else if (!i_stall) begin
      r_rem[0] <= REM_W'(w_abs);
      r_den[0] <= i_denr;
      r_neg[0] <= w_neg;
      r_spc[0] <= w_spc;
      for (int k = 1; k < FRAC_BITS; k++) begin
        r_rem[k] <= div_rem(r_rem[k-1], r_den[k-1]);
        r_den[k] <= r_den[k-1];
      end
      r_quo[1] <= FRAC_BITS'(div_ge(r_rem[0], r_den[0]));
      for (int k = 2; k <= FRAC_BITS; k++) begin
        r_quo[k] <= {r_quo[k-1][FRAC_BITS-2:0], div_ge(r_rem[k-1], r_den[k-1])};
      end
      for (int k = 1; k <= FRAC_BITS; k++) begin
        r_neg[k] <= r_neg[k-1];
        r_spc[k] <= r_spc[k-1];
      end
      o_ssim <= w_result;
    end
  end

endmodule

// File: rtl/hssim_ratio.sv
// HSSIM ratio stage: per-lane clamped SSIM divide, beat valid chain and frame-end marking.
module hssim_ratio
  import hssim_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned NUMR_BIT_WIDTH  = 36,
  parameter int unsigned DENR_BIT_WIDTH  = 36,
  parameter int unsigned OUT_BIT_WIDTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  hssim_ratio_if.slave bus
);

  localparam int unsigned LAT   = HSSIM_RATIO_LAT;
  localparam int unsigned BEATS = (IMAGE_DIM * IMAGE_DIM) / PIXELS_PER_BEAT;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // r_vld[k] travels alongside divider stage k; the output register is the last slot.
  logic [LAT-2:0]   r_vld;
  logic             r_out_valid;
  logic             r_out_last;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last_hit;

  assign w_last_hit    = (r_cnt == CNT_W'(BEATS - 1));
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;

  for (genvar g = 0; g < PIXELS_PER_BEAT; g++) begin : g_lane
    hssim_div_lane #(
      .NUMR_W (NUMR_BIT_WIDTH),
      .DENR_W (DENR_BIT_WIDTH),
      .OUT_W  (OUT_BIT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_stall (stall),
      .i_numr  (bus.numr_in[g*NUMR_BIT_WIDTH +: NUMR_BIT_WIDTH]),
      .i_denr  (bus.denr_in[g*DENR_BIT_WIDTH +: DENR_BIT_WIDTH]),
      .o_ssim  (bus.ssim_out[g*OUT_BIT_WIDTH +: OUT_BIT_WIDTH])
    );
  end

  // Valid chain and frame counter; a beat is counted once, as it enters the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_cnt       <= '0;
    end else if (!stall) begin
      r_vld       <= {r_vld[LAT-3:0], bus.in_valid};
      r_out_valid <= r_vld[LAT-2];
      r_out_last  <= r_vld[LAT-2] && w_last_hit;
      if (r_vld[LAT-2]) begin
        r_cnt <= w_last_hit ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
